demultiplexador_quadro: RTL
===========================

Name: demultiplexador_quadro

Overview:
- Receive-side counterpart of the 8:1 16-bit word multiplexer: takes one 16-bit word stream and distributes each word into one of eight registered output lanes.
- Destination comes from an explicit 3-bit `controle` (direct mode) or an internal wrapping address counter (sequential/TDM mode).
- Tracks which lanes were written in the current frame, pulses when all eight lanes have been filled, and flags overwrites within a frame.
- Sits at the far end of a word-serial link that a counter-driven multiplexer feeds.

Parameters:
- LARGURA, 16, width of the data word and of each output lane.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- entrada  input  LARGURA  incoming data word.
- controle  input  3  destination lane in direct mode; ignored in sequential mode.
- valido  input  1  entrada/controle valid this cycle; word is accepted on the rising edge.
- modo_sequencial  input  1  1 = destination is endereco_atual; 0 = destination is controle.
- limpar  input  1  synchronous frame clear.
- saida0 … saida7  output  LARGURA each  registered output lanes.
- atualizado  output  8  one-hot, one-cycle strobe; bit d high the cycle after lane d was written.
- quadro_completo  output  1  one-cycle pulse when the eighth distinct lane of a frame has been written.
- endereco_atual  output  3  sequential-mode destination counter.
- erro_sobrescrita  output  1  sticky flag: a lane was written twice within one frame.

Behaviour:
Reset
- Reset is asynchronous and active-low; reset_n low forces every register immediately, independent of clock.
- While reset_n is low:
  - saida0..saida7 = 0
  - atualizado = 8'h00
  - quadro_completo = 0
  - endereco_atual = 0
  - erro_sobrescrita = 0
  - internal mascara[7:0] = 0
- Release of reset_n takes effect at the next clock edge with no extra delay.

Destination and write (all on the rising clock edge)
- d = modo_sequencial ? endereco_atual : controle.
- Accepted write (valido = 1, limpar = 0):
  - saida_d <= entrada; the other seven lanes hold.
  - atualizado <= (1 << d).
  - Latency: exactly 1 cycle from the accepting edge to the new value on saida_d and the atualizado strobe.
- No accepted write: atualizado <= 0; all lanes hold.
- No back-pressure: the block accepts one word every cycle.

Sequential counter
- On an accepted write with modo_sequencial = 1: endereco_atual <= endereco_atual + 1, wrapping 7 -> 0.
- In direct mode, endereco_atual holds.
- Switching modo_sequencial mid-frame is legal; mascara and endereco_atual are unaffected by the switch.

Frame tracking
- mascara records lanes written in the current frame.
- On an accepted write, let m = mascara | (1 << d).
- If mascara[d] was already 1: erro_sobrescrita <= 1 (sticky). The write is still performed.
- If m == 8'hFF:
  - quadro_completo <= 1 for one cycle, aligned with atualizado.
  - mascara <= 0; the next write starts a new frame.
- Otherwise: mascara <= m; quadro_completo <= 0.

limpar (synchronous)
- Clears mascara, endereco_atual and erro_sobrescrita.
- Does not clear saida0..7.
- limpar and valido in the same cycle: limpar has priority.
  - The word is discarded: no lane change, atualizado = 0, quadro_completo = 0.

Other boundaries
- Overwrite on the completing write: a write with mascara[d] already set cannot complete a frame (m == mascara), so completion always comes from a new lane.
- Reset asserted mid-frame: all state returns to reset values immediately; any pending strobes are lost.

Test Plan:
1. Reset: reset_n low mid-cycle -> all saidas 0, atualizado 00, endereco_atual 0, erro 0 without waiting for a clock edge. Release reset_n, idle 3 cycles -> outputs remain 0.
2. Direct mode: one cycle each of entrada 16'hA5A5 with controle 3, then 16'h1234 with controle 0, valido = 1.
   - saida3 = A5A5 and atualizado = 8'h08 one cycle after the first.
   - saida0 = 1234 and atualizado = 8'h01 after the second.
   - Other lanes stay 0; quadro_completo stays 0.
3. Sequential mode, 8 consecutive valid words 16'h0010..16'h0017:
   - saidaN = 16'h0010 + N.
   - endereco_atual steps 1..7 then wraps to 0.
   - quadro_completo pulses exactly once, on the cycle atualizado = 8'h80.
   - erro_sobrescrita stays 0.
4. Overwrite: direct mode writes to lanes 2, then 2 again -> erro_sobrescrita = 1 after the second write and stays 1.
   - Then limpar for one cycle -> erro = 0, endereco_atual = 0, saida2 unchanged.
5. Priority: limpar = 1 with valido = 1, controle 5, entrada 16'hFFFF -> saida5 unchanged, atualizado = 00.
   - Then 8 distinct direct writes -> one quadro_completo pulse, which proves mascara was cleared.
6. Mixed mode: 4 sequential writes (lanes 0-3), then direct writes to lanes 7, 6, 5, 4 -> quadro_completo on the lane-4 write, no error.
   - A following sequential write lands in lane 4, since endereco_atual held at 4.

Source files
------------

// File: rtl/demultiplexador_quadro.sv
// Word demultiplexer: steers a 16-bit stream into eight registered lanes,
// tracking per-frame lane coverage, completion and overwrites.
module demultiplexador_quadro #(
  parameter int LARGURA = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [LARGURA-1:0] entrada,
  input  logic [2:0]         controle,
  input  logic               valido,
  input  logic               modo_sequencial,
  input  logic               limpar,
  output logic [LARGURA-1:0] saida0,
  output logic [LARGURA-1:0] saida1,
  output logic [LARGURA-1:0] saida2,
  output logic [LARGURA-1:0] saida3,
  output logic [LARGURA-1:0] saida4,
  output logic [LARGURA-1:0] saida5,
  output logic [LARGURA-1:0] saida6,
  output logic [LARGURA-1:0] saida7,
  output logic [7:0]         atualizado,
  output logic               quadro_completo,
  output logic [2:0]         endereco_atual,
  output logic               erro_sobrescrita
);

  logic [LARGURA-1:0] lanes_q [8];
  logic [7:0] mascara_q, mascara_d;
  logic [7:0] atu_q, atu_d;
  logic       qc_q, qc_d;
  logic [2:0] end_q, end_d;
  logic       err_q, err_d;

  logic [2:0] destino;
  logic [7:0] sel;
  logic [7:0] m;
  logic       aceito;

  assign destino = modo_sequencial ? end_q : controle;
  assign sel     = 8'b1 << destino;
  assign m       = mascara_q | sel;
  assign aceito  = valido & ~limpar;

  always_comb begin
    mascara_d = mascara_q;
    atu_d     = 8'h00;
    qc_d      = 1'b0;
    end_d     = end_q;
    err_d     = err_q;
    if (limpar) begin
      mascara_d = 8'h00;
      end_d     = 3'd0;
      err_d     = 1'b0;
    end else if (valido) begin
      atu_d = sel;
      if (modo_sequencial)
        end_d = end_q + 3'd1;
      if ((mascara_q & sel) != 8'h00)
        err_d = 1'b1;
      // Completing write starts a fresh frame immediately
      if (m == 8'hFF) begin
        qc_d      = 1'b1;
        mascara_d = 8'h00;
      end else begin
        mascara_d = m;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mascara_q <= 8'h00;
      atu_q     <= 8'h00;
      qc_q      <= 1'b0;
      end_q     <= 3'd0;
      err_q     <= 1'b0;
    end else begin
      mascara_q <= mascara_d;
      atu_q     <= atu_d;
      qc_q      <= qc_d;
      end_q     <= end_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++)
        lanes_q[i] <= '0;
    end else if (aceito) begin
      lanes_q[destino] <= entrada;
    end
  end

  assign saida0           = lanes_q[0];
  assign saida1           = lanes_q[1];
  assign saida2           = lanes_q[2];
  assign saida3           = lanes_q[3];
  assign saida4           = lanes_q[4];
  assign saida5           = lanes_q[5];
  assign saida6           = lanes_q[6];
  assign saida7           = lanes_q[7];
  assign atualizado       = atu_q;
  assign quadro_completo  = qc_q;
  assign endereco_atual   = end_q;
  assign erro_sobrescrita = err_q;

endmodule
